// File: rtl/data_mem_pkg.sv
// Shared types and helpers for the data-memory access stage.
package data_mem_pkg;

  typedef enum logic [1:0] {SZ_B = 2'b00, SZ_H = 2'b01, SZ_W = 2'b10, SZ_D = 2'b11} mem_size_t;
  typedef enum logic [1:0] {IDLE = 2'b00, BUSY = 2'b01, DONE = 2'b10, FAULT = 2'b11} dms_state_t;

  // Byte-enable mask for a size, before shifting to its lane.
  function automatic logic [7:0] size_mask(input mem_size_t size);
    case (size)
      SZ_B:    size_mask = 8'h01;
      SZ_H:    size_mask = 8'h03;
      SZ_W:    size_mask = 8'h0F;
      default: size_mask = 8'hFF;
    endcase
  endfunction

endpackage

// File: rtl/data_mem_stage_lane_align.sv
// Byte-lane steering: enables, store-data shift, load extraction and alignment check.
module lane_align
  import data_mem_pkg::*;
(
  input  logic [2:0]  addr,
  input  mem_size_t   size,
  input  logic [63:0] wdata,
  input  logic [63:0] rdata,
  output logic [7:0]  be,
  output logic [63:0] wdata_sh,
  output logic [63:0] rdata_ex,
  output logic        misaligned
);

  logic [7:0]  bmask;
  logic [63:0] dmask;
  logic [63:0] rdata_sh;

  assign bmask    = size_mask(size);
  assign be       = bmask << addr;
  assign wdata_sh = wdata << {addr, 3'b000};
  assign rdata_sh = rdata >> {addr, 3'b000};
  assign rdata_ex = rdata_sh & dmask;

  for (genvar i = 0; i < 8; i++) begin : g_dmask
    assign dmask[8*i +: 8] = {8{bmask[i]}};
  end

  always_comb begin
    misaligned = 1'b0;
    case (size)
      SZ_B:    misaligned = 1'b0;
      SZ_H:    misaligned = addr[0];
      SZ_W:    misaligned = |addr[1:0];
      SZ_D:    misaligned = |addr;
      default: misaligned = 1'b0;
    endcase
  end

endmodule

// File: rtl/data_mem_stage.sv
// Memory-access stage: issues loads/stores over a ready handshake with timeout, stalls the CPU meanwhile.
module data_mem_stage
  import data_mem_pkg::*;
#(
  parameter  int TIMEOUT = 16,
  localparam int CNT_W   = $clog2(TIMEOUT + 1)
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [63:0] ALU_result,
  input  logic [63:0] ReadData2_out,
  input  logic        MemRead,
  input  logic        MemWrite,
  input  logic [1:0]  mem_size,
  output logic        stall,
  output logic [63:0] load_data,
  output logic        done,
  output logic        fault,
  output logic        mem_req,
  output logic        mem_we,
  output logic [63:0] mem_addr,
  output logic [63:0] mem_wdata,
  output logic [7:0]  mem_be,
  input  logic        mem_ready,
  input  logic [63:0] mem_rdata
);

  dms_state_t       state, nxt;
  logic [CNT_W-1:0] cnt;
  mem_size_t        size_q;

  logic        access, illegal, misal;
  logic [2:0]  la_addr;
  mem_size_t   la_size;
  logic [7:0]  be_c;
  logic [63:0] wdata_c, rdata_c;

  assign access  = MemRead | MemWrite;
  assign illegal = MemRead & MemWrite;

  // Live inputs steer the lanes in IDLE; afterwards the captured request does.
  assign la_addr = (state == IDLE) ? ALU_result[2:0] : mem_addr[2:0];
  assign la_size = (state == IDLE) ? mem_size_t'(mem_size) : size_q;

  lane_align u_lane (
    .addr       (la_addr),
    .size       (la_size),
    .wdata      (ReadData2_out),
    .rdata      (mem_rdata),
    .be         (be_c),
    .wdata_sh   (wdata_c),
    .rdata_ex   (rdata_c),
    .misaligned (misal)
  );

  always_comb begin
    nxt   = state;
    stall = 1'b0;
    done  = 1'b0;
    fault = 1'b0;
    case (state)
      IDLE: if (access) begin
        stall = 1'b1;
        nxt   = (illegal || misal) ? FAULT : BUSY;
      end
      BUSY: begin
        stall = 1'b1;
        if (mem_ready)                          nxt = DONE;
        else if (cnt == CNT_W'(TIMEOUT - 1))    nxt = FAULT;
      end
      DONE: begin
        done = 1'b1;
        nxt  = IDLE;
      end
      FAULT: begin
        fault = 1'b1;
        nxt   = IDLE;
      end
      default: nxt = IDLE;
    endcase
    if (!reset) stall = 1'b0;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      cnt       <= '0;
      size_q    <= SZ_B;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_be    <= '0;
      load_data <= '0;
    end else begin
      state <= nxt;
      case (state)
        IDLE: if (nxt == BUSY) begin
          mem_req   <= 1'b1;
          mem_we    <= MemWrite;
          mem_addr  <= ALU_result;
          mem_wdata <= wdata_c;
          mem_be    <= be_c;
          size_q    <= mem_size_t'(mem_size);
          cnt       <= '0;
        end
        BUSY: begin
          if (mem_ready) begin
            mem_req <= 1'b0;
            if (!mem_we) load_data <= rdata_c;
          end else if (nxt == FAULT) begin
            mem_req <= 1'b0;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_data_mem_stage.sv
// Randomized self-checking bench for data_mem_stage with a transaction-level reference model.
module tb_data_mem_stage;

  localparam int TO = 16;

  logic        clk, reset;
  logic [63:0] ALU_result, ReadData2_out;
  logic        MemRead, MemWrite;
  logic [1:0]  mem_size;
  logic        stall, done, fault, mem_req, mem_we, mem_ready;
  logic [63:0] load_data, mem_addr, mem_wdata, mem_rdata;
  logic [7:0]  mem_be;

  int n_tests = 0;
  int n_fail  = 0;
  logic [63:0] exp_ld = '0;

  data_mem_stage #(.TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset), .ALU_result(ALU_result), .ReadData2_out(ReadData2_out),
    .MemRead(MemRead), .MemWrite(MemWrite), .mem_size(mem_size), .stall(stall),
    .load_data(load_data), .done(done), .fault(fault), .mem_req(mem_req), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_be(mem_be), .mem_ready(mem_ready),
    .mem_rdata(mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // One instruction: entered just after a rising edge with the DUT idle, leaves it the same way.
  task automatic access(input logic rd, input logic wr, input logic [63:0] addr, input logic [1:0] sz,
                        input logic [63:0] wd, input logic [63:0] rdat, input int waitn);
    int stall_n, req_n, busy_n, cyc, lane, nb;
    int exp_stall, exp_req;
    logic bad, got_done, got_fault, unstable;
    logic [63:0] a0, w0;
    logic [7:0]  be0;
    logic        we0;
    logic [127:0] m;

    MemRead = rd; MemWrite = wr; ALU_result = addr; mem_size = sz; ReadData2_out = wd;
    if (!rd && !wr) begin
      #1;
      chk("idle_stall", {63'b0, stall}, 64'd0);
      @(posedge clk); #1;
      chk("idle_req", {63'b0, mem_req}, 64'd0);
      return;
    end

    lane = int'(addr[2:0]);
    nb   = 1 << sz;
    bad  = (rd && wr) || ((addr % 64'(nb)) != 0);
    stall_n = 0; req_n = 0; busy_n = 0; cyc = 0;
    got_done = 0; got_fault = 0; unstable = 0;
    a0 = '0; w0 = '0; be0 = '0; we0 = 0;

    while (cyc < 200) begin
      #1;
      if (stall) stall_n++;
      if (mem_req) begin
        if (req_n == 0) begin a0 = mem_addr; w0 = mem_wdata; be0 = mem_be; we0 = mem_we; end
        else if (mem_addr !== a0 || mem_wdata !== w0 || mem_be !== be0 || mem_we !== we0) unstable = 1;
        req_n++;
      end
      if (done || fault) begin
        got_done = done; got_fault = fault;
        break;
      end
      mem_ready = mem_req ? (busy_n == waitn) : 1'($urandom_range(0, 1));
      mem_rdata = (mem_req && busy_n == waitn) ? rdat : {$urandom, $urandom};
      if (mem_req) busy_n++;
      @(posedge clk); #1;
      cyc++;
    end
    if (cyc >= 200) chk("cycle_bound", 64'd1, 64'd0);

    if (bad) begin
      exp_stall = 1; exp_req = 0;
    end else if (waitn < TO) begin
      exp_stall = waitn + 2; exp_req = waitn + 1;
    end else begin
      exp_stall = TO + 1; exp_req = TO;
    end
    chk("done",   {63'b0, got_done},  {63'b0, !bad && waitn < TO});
    chk("fault",  {63'b0, got_fault}, {63'b0, bad || waitn >= TO});
    chk("stall_cycles", 64'(stall_n), 64'(exp_stall));
    chk("req_cycles",   64'(req_n),   64'(exp_req));
    if (!bad) begin
      chk("addr",  a0, addr);
      chk("we",    {63'b0, we0}, {63'b0, wr});
      chk("be",    {56'b0, be0}, 64'(((1 << nb) - 1) << lane));
      chk("wdata", w0, wd << (8 * lane));
      chk("req_stable", {63'b0, unstable}, 64'd0);
      if (rd && waitn < TO) begin
        m = (128'd1 << (8 * nb)) - 128'd1;
        exp_ld = 64'((128'(rdat) >> (8 * lane)) & m);
      end
    end
    chk("load_data", load_data, exp_ld);

    mem_ready = 1'b0;
    @(posedge clk); #1;
    chk("no_reissue", {63'b0, mem_req}, 64'd0);
  endtask

  initial begin
    int kind, waitn;
    logic rd, wr;
    reset = 1'b0; MemRead = 0; MemWrite = 0; ALU_result = '0; ReadData2_out = '0;
    mem_size = 2'b00; mem_ready = 0; mem_rdata = '0;
    #12;
    chk("rst_req",   {63'b0, mem_req}, 64'd0);
    chk("rst_stall", {63'b0, stall},   64'd0);
    chk("rst_done",  {62'b0, done, fault}, 64'd0);
    chk("rst_be",    {56'b0, mem_be},  64'd0);
    chk("rst_ld",    load_data,        64'd0);
    reset = 1'b1;
    @(posedge clk); #1;

    access(0, 1, 64'h40, 2'b11, 64'h1122334455667788, 64'h0, 0);
    access(1, 0, 64'h43, 2'b00, 64'h0, 64'hAABBCCDDEEFF0011, 3);
    chk("ld_byte", load_data, 64'h00000000000000EE);
    access(1, 0, 64'h42, 2'b10, 64'h0, 64'hFFFF_FFFF_FFFF_FFFF, 0);
    access(1, 1, 64'h48, 2'b11, 64'h5, 64'h6, 0);
    access(1, 0, 64'h50, 2'b11, 64'h0, 64'h1234, 100);
    access(0, 1, 64'h60, 2'b01, 64'hBEEF, 64'h0, 1);
    access(1, 0, 64'h46, 2'b01, 64'h0, 64'hCAFE_0000_0000_0000, 0);
    chk("ld_half", load_data, 64'h000000000000CAFE);
    access(1, 0, 64'h88, 2'b10, 64'h0, 64'h0123456789ABCDEF, TO - 1);

    // Reset in the middle of a pending request.
    MemRead = 1; MemWrite = 0; mem_size = 2'b11; ALU_result = 64'h80;
    repeat (3) @(posedge clk);
    #2;
    chk("busy_req", {63'b0, mem_req}, 64'd1);
    reset = 1'b0;
    #1;
    chk("abort_req",   {63'b0, mem_req}, 64'd0);
    chk("abort_stall", {63'b0, stall},   64'd0);
    chk("abort_done",  {63'b0, done},    64'd0);
    chk("abort_ld",    load_data,        64'd0);
    exp_ld = '0;
    MemRead = 0;
    @(posedge clk); #1;
    reset = 1'b1;
    repeat (3) begin
      @(posedge clk); #1;
      chk("post_rst_req",   {63'b0, mem_req}, 64'd0);
      chk("post_rst_stall", {63'b0, stall},   64'd0);
    end

    for (int i = 0; i < 150; i++) begin
      kind = $urandom_range(0, 9);
      rd = 1'($urandom_range(0, 1));
      wr = !rd;
      if (kind == 0) begin rd = 0; wr = 0; end
      if (kind == 1) begin rd = 1; wr = 1; end
      case ($urandom_range(0, 9))
        0:       waitn = TO + $urandom_range(0, 3);
        1:       waitn = TO - 1;
        default: waitn = $urandom_range(0, 4);
      endcase
      access(rd, wr, {$urandom, $urandom}, 2'($urandom_range(0, 3)),
             {$urandom, $urandom}, {$urandom, $urandom}, waitn);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
